pll_lock_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 67 ++++++
 rtl/pll_lock_sequencer_sync.sv | 27 ++
 rtl/pll_lock_sequencer.sv | 151 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared definitions for the PLL lock sequencer.
//   state_t          - FSM state encoding, also exported on the debug state port
//   DEF_*            - default sequencer parameters
//   clog2()          - ceiling log2, for sizing the shared timer at instantiation
//   state_outputs()  - per-state values of the registered sequencer outputs
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_PWRDN     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_QUALIFY   = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   localparam int unsigned DEF_PWRDN_CYCLES  = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
   localparam int unsigned DEF_STABLE_CYCLES = 1024;
   localparam int unsigned DEF_RST_HOLD      = 64;
   localparam int unsigned DEF_MAX_RETRIES   = 7;
   localparam int unsigned DEF_CNT_W         = 17;

   // Number of bits needed to count 0..value-1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned n;
      v = (value > 0) ? value - 1 : 0;
      n = 0;
      while (v > 0) begin
         n = n + 1;
         v = v >> 1;
      end
      return n;
   endfunction

   typedef struct packed {
      logic pwrdn_n;
      logic sys_reset;
      logic locked_ok;
      logic fault;
   } seq_out_t;

   // The PLL is powered except in PWRDN and FAIL; the downstream reset is
   // released only in RUN.
   function automatic seq_out_t state_outputs(input state_t s);
      seq_out_t o;
      o.pwrdn_n   = 1'b1;
      o.sys_reset = 1'b1;
      o.locked_ok = 1'b0;
      o.fault     = 1'b0;
      case (s)
         ST_PWRDN: o.pwrdn_n = 1'b0;
         ST_RUN: begin
            o.sys_reset = 1'b0;
            o.locked_ok = 1'b1;
         end
         ST_FAIL: begin
            o.pwrdn_n = 1'b0;
            o.fault   = 1'b1;
         end
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync.sv
// sync_2ff: generic 1-bit double-flop synchronizer.
//   clk   - destination clock
//   reset - synchronous, active-high; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronized output, two clk cycles behind d
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: supervises a fabric PLL from the free-running reference
// clock. Powers the PLL up, qualifies its LOCK, holds the PLL-domain reset
// until lock is stable, retries on lock timeout, relocks after loss of lock
// and raises a fault after a bounded number of retries.
//   clk             - reference clock, free running
//   reset           - synchronous, active-high
//   pll_lock        - PLL LOCK, asynchronous to clk
//   restart         - single-cycle pulse, full restart from PWRDN
//   pll_powerdown_n - to PLL POWERDOWN_N
//   sys_reset       - active-high reset for the PLL-clock domain
//   locked_ok       - high only in RUN
//   fault           - high only in FAIL
//   retry_count     - lock-timeout retries since reset/restart
//   loss_count      - RUN loss-of-lock events since reset, saturating
//   state           - encoded FSM state
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PWRDN     | PLL held in powerdown for PWRDN_CYCLES
// WAIT_LOCK | PLL powered, waiting for lock; retry after LOCK_TIMEOUT
// QUALIFY   | lock must stay high for STABLE_CYCLES contiguous cycles
// RELEASE   | lock qualified; sys_reset held RST_HOLD more cycles
// RUN       | sys_reset released; any lock drop counts a loss and relocks
// FAIL      | retries exhausted; PLL powered down until reset/restart
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned PWRDN_CYCLES  = DEF_PWRDN_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned RST_HOLD      = DEF_RST_HOLD,
   parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_lock,
   input  logic       restart,
   output logic       pll_powerdown_n,
   output logic       sys_reset,
   output logic       locked_ok,
   output logic       fault,
   output logic [3:0] retry_count,
   output logic [7:0] loss_count,
   output logic [2:0] state
);

   // Terminal counts: the timer starts at 0 on state entry, so a state lasting
   // N cycles expires when the timer reads N-1.
   localparam logic [CNT_W-1:0] PWRDN_LAST  = CNT_W'(PWRDN_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);
   localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

   logic             lock;
   state_t           cur_state;
   state_t           nxt_state;
   logic [CNT_W-1:0] timer;
   logic             timer_clr;
   logic [3:0]       nxt_retry;
   logic [7:0]       nxt_loss;
   seq_out_t         nxt_out;

   sync_2ff #(
      .RESET_VAL (1'b0)
   ) u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock)
   );

   // Priority inside each state: restart, then lock drop, then timer expiry.
   always_comb begin
      nxt_state = cur_state;
      nxt_retry = retry_count;
      nxt_loss  = loss_count;
      timer_clr = 1'b0;
      if (restart) begin
         nxt_state = ST_PWRDN;
         nxt_retry = 4'd0;
         timer_clr = 1'b1;
      end else begin
         case (cur_state)
            ST_PWRDN: begin
               if (timer == PWRDN_LAST) nxt_state = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (lock) begin
                  nxt_state = ST_QUALIFY;
               end else if (timer == TIMEOUT_LAST) begin
                  if (retry_count < RETRY_MAX) begin
                     nxt_retry = retry_count + 4'd1;
                     nxt_state = ST_PWRDN;
                  end else begin
                     nxt_state = ST_FAIL;
                  end
               end
            end
            ST_QUALIFY: begin
               if (!lock)                    nxt_state = ST_WAIT_LOCK;
               else if (timer == STABLE_LAST) nxt_state = ST_RELEASE;
            end
            ST_RELEASE: begin
               if (!lock)                  nxt_state = ST_WAIT_LOCK;
               else if (timer == HOLD_LAST) nxt_state = ST_RUN;
            end
            ST_RUN: begin
               // The PLL stays powered; its own relock handles the recovery.
               if (!lock) begin
                  nxt_state = ST_WAIT_LOCK;
                  if (loss_count != 8'hFF) nxt_loss = loss_count + 8'd1;
               end
            end
            ST_FAIL: ;
            default: nxt_state = ST_PWRDN;
         endcase
      end
      if (nxt_state != cur_state) timer_clr = 1'b1;
   end

   assign nxt_out = state_outputs(nxt_state);

   // Outputs are decoded from the next state and registered with it, so
   // nothing reaches a port combinationally from pll_lock.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state       <= ST_PWRDN;
         timer           <= '0;
         retry_count     <= 4'd0;
         loss_count      <= 8'd0;
         pll_powerdown_n <= 1'b0;
         sys_reset       <= 1'b1;
         locked_ok       <= 1'b0;
         fault           <= 1'b0;
      end else begin
         cur_state       <= nxt_state;
         timer           <= timer_clr ? '0 : timer + CNT_W'(1);
         retry_count     <= nxt_retry;
         loss_count      <= nxt_loss;
         pll_powerdown_n <= nxt_out.pwrdn_n;
         sys_reset       <= nxt_out.sys_reset;
         locked_ok       <= nxt_out.locked_ok;
         fault           <= nxt_out.fault;
      end
   end

   assign state = cur_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

   localparam int unsigned TB_PWRDN   = 4;
   localparam int unsigned TB_TIMEOUT = 20;
   localparam int unsigned TB_STABLE  = 8;
   localparam int unsigned TB_HOLD    = 3;
   localparam int unsigned TB_RETRIES = 2;
   localparam int unsigned TB_CNT_W   = pll_seq_pkg::clog2(TB_TIMEOUT + 1);

   localparam int F_ST   = 0;
   localparam int F_PD   = 1;
   localparam int F_SR   = 2;
   localparam int F_OK   = 3;
   localparam int F_FLT  = 4;
   localparam int F_RET  = 5;
   localparam int F_LOSS = 6;

   localparam int S_PWRDN = 0;
   localparam int S_WAIT  = 1;
   localparam int S_QUAL  = 2;
   localparam int S_REL   = 3;
   localparam int S_RUN   = 4;
   localparam int S_FAIL  = 5;

   logic       clk;
   logic       reset;
   logic       pll_lock;
   logic       restart;
   logic       pll_powerdown_n;
   logic       sys_reset;
   logic       locked_ok;
   logic       fault;
   logic [3:0] retry_count;
   logic [7:0] loss_count;
   logic [2:0] state;

   typedef struct {
      int    at;
      string name;
      int    sel;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   total;
   int   bad;

   pll_lock_sequencer #(
      .PWRDN_CYCLES  (TB_PWRDN),
      .LOCK_TIMEOUT  (TB_TIMEOUT),
      .STABLE_CYCLES (TB_STABLE),
      .RST_HOLD      (TB_HOLD),
      .MAX_RETRIES   (TB_RETRIES),
      .CNT_W         (TB_CNT_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pll_lock        (pll_lock),
      .restart         (restart),
      .pll_powerdown_n (pll_powerdown_n),
      .sys_reset       (sys_reset),
      .locked_ok       (locked_ok),
      .fault           (fault),
      .retry_count     (retry_count),
      .loss_count      (loss_count),
      .state           (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle 0 is the cycle in which reset is deasserted.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic int get_field(input int sel);
      case (sel)
         F_ST:   return int'(state);
         F_PD:   return int'(pll_powerdown_n);
         F_SR:   return int'(sys_reset);
         F_OK:   return int'(locked_ok);
         F_FLT:  return int'(fault);
         F_RET:  return int'(retry_count);
         F_LOSS: return int'(loss_count);
         default: return -1;
      endcase
   endfunction

   function automatic string fname(input int sel);
      case (sel)
         F_ST:   return "state";
         F_PD:   return "pll_powerdown_n";
         F_SR:   return "sys_reset";
         F_OK:   return "locked_ok";
         F_FLT:  return "fault";
         F_RET:  return "retry_count";
         F_LOSS: return "loss_count";
         default: return "?";
      endcase
   endfunction

   // Monitor: pops every expectation due this cycle and compares.
   always @(negedge clk) begin
      exp_t e;
      int   act;
      if (!reset) begin
         while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.at < cyc) begin
               bad++;
               $display("FAIL %s: %s check for cycle %0d missed at cycle %0d",
                        e.name, fname(e.sel), e.at, cyc);
            end else begin
               act = get_field(e.sel);
               if (act != e.val) begin
                  bad++;
                  $display("FAIL %s: cycle %0d %s got %0d want %0d",
                           e.name, cyc, fname(e.sel), act, e.val);
               end
            end
         end
      end
   end

   task automatic expect_f(input int at, input string name, input int sel, input int val);
      exp_t e;
      e.at = at;
      e.name = name;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic expect_all(input int at, input string name, input int st, input int pd,
                             input int sr, input int ok, input int flt);
      expect_f(at, name, F_ST, st);
      expect_f(at, name, F_PD, pd);
      expect_f(at, name, F_SR, sr);
      expect_f(at, name, F_OK, ok);
      expect_f(at, name, F_FLT, flt);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic wait_to(input int n);
      int guard;
      guard = 0;
      while (cyc < n && guard < 20000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (cyc < n) begin
         total++;
         bad++;
         $display("FAIL wait_to: cycle %0d not reached (at %0d)", n, cyc);
      end
   endtask

   task automatic wait_drain(input int budget);
      int g;
      g = 0;
      while (sb.size() > 0 && g < budget) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d checks pending, want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int want_loss;
      total    = 0;
      bad      = 0;
      reset    = 1'b1;
      pll_lock = 1'b0;
      restart  = 1'b0;

      // Nominal lock: pin rises at cycle 6.
      do_reset();
      expect_all(0, "reset_vals", S_PWRDN, 0, 1, 0, 0);
      expect_f(0, "reset_vals", F_RET, 0);
      expect_f(0, "reset_vals", F_LOSS, 0);
      expect_all(3, "nom_pwrdn_end", S_PWRDN, 0, 1, 0, 0);
      expect_all(4, "nom_wait", S_WAIT, 1, 1, 0, 0);
      expect_f(8, "nom_wait_last", F_ST, S_WAIT);
      expect_all(9, "nom_qualify", S_QUAL, 1, 1, 0, 0);
      expect_f(16, "nom_qualify_last", F_ST, S_QUAL);
      expect_all(17, "nom_release", S_REL, 1, 1, 0, 0);
      expect_all(19, "nom_release_last", S_REL, 1, 1, 0, 0);
      expect_all(20, "nom_run", S_RUN, 1, 0, 1, 0);
      wait_to(6);
      pll_lock = 1'b1;
      wait_drain(100);

      // No lock: three powerdown pulses, two retries, then FAIL; restart out of FAIL.
      pll_lock = 1'b0;
      do_reset();
      expect_all(23, "nolock_wait1_end", S_WAIT, 1, 1, 0, 0);
      expect_f(23, "nolock_wait1_end", F_RET, 0);
      expect_all(24, "nolock_pwrdn2", S_PWRDN, 0, 1, 0, 0);
      expect_f(24, "nolock_pwrdn2", F_RET, 1);
      expect_f(27, "nolock_pwrdn2_end", F_PD, 0);
      expect_f(28, "nolock_wait2", F_PD, 1);
      expect_f(47, "nolock_wait2_end", F_ST, S_WAIT);
      expect_all(48, "nolock_pwrdn3", S_PWRDN, 0, 1, 0, 0);
      expect_f(48, "nolock_pwrdn3", F_RET, 2);
      expect_f(52, "nolock_wait3", F_ST, S_WAIT);
      expect_f(71, "nolock_wait3_end", F_ST, S_WAIT);
      expect_all(72, "nolock_fail", S_FAIL, 0, 1, 0, 1);
      expect_f(72, "nolock_fail", F_RET, 2);
      expect_all(172, "nolock_fail_held", S_FAIL, 0, 1, 0, 1);
      expect_all(173, "restart_pre", S_FAIL, 0, 1, 0, 1);
      expect_all(174, "restart_pwrdn", S_PWRDN, 0, 1, 0, 0);
      expect_f(174, "restart_pwrdn", F_RET, 0);
      expect_f(177, "restart_pwrdn_end", F_ST, S_PWRDN);
      expect_all(178, "restart_wait", S_WAIT, 1, 1, 0, 0);
      expect_f(178, "restart_wait", F_RET, 0);
      wait_to(173);
      restart = 1'b1;
      wait_to(174);
      restart = 1'b0;
      wait_drain(100);

      // Glitch during QUALIFY, loss in RUN with relock, restart coincident with a drop.
      pll_lock = 1'b0;
      do_reset();
      expect_f(13, "glitch_qual", F_ST, S_QUAL);
      expect_f(14, "glitch_back", F_ST, S_WAIT);
      expect_f(14, "glitch_back", F_RET, 0);
      expect_f(15, "glitch_requal", F_ST, S_QUAL);
      expect_f(22, "glitch_requal_end", F_ST, S_QUAL);
      expect_f(23, "glitch_release", F_ST, S_REL);
      expect_all(26, "glitch_run", S_RUN, 1, 0, 1, 0);
      expect_f(26, "glitch_run", F_RET, 0);
      expect_all(32, "loss_pre", S_RUN, 1, 0, 1, 0);
      expect_all(33, "loss_reset", S_WAIT, 1, 1, 0, 0);
      expect_f(33, "loss_reset", F_LOSS, 1);
      expect_f(38, "loss_qualify", F_ST, S_QUAL);
      expect_f(40, "loss_no_pwrdn", F_PD, 1);
      expect_f(47, "loss_no_pwrdn", F_PD, 1);
      expect_all(49, "loss_rerun", S_RUN, 1, 0, 1, 0);
      expect_f(49, "loss_rerun", F_RET, 0);
      expect_f(54, "simul_pre", F_ST, S_RUN);
      expect_all(55, "simul_restart", S_PWRDN, 0, 1, 0, 0);
      expect_f(55, "simul_restart", F_LOSS, 1);
      expect_f(55, "simul_restart", F_RET, 0);
      wait_to(6);
      pll_lock = 1'b1;
      wait_to(11);
      pll_lock = 1'b0;
      wait_to(12);
      pll_lock = 1'b1;
      wait_to(30);
      pll_lock = 1'b0;
      wait_to(35);
      pll_lock = 1'b1;
      wait_to(52);
      pll_lock = 1'b0;
      wait_to(54);
      restart = 1'b1;
      wait_to(55);
      restart = 1'b0;
      wait_drain(100);

      // 260 losses in RUN: one-cycle pin drops every 15 cycles.
      pll_lock = 1'b1;
      do_reset();
      expect_all(16, "sat_first_run", S_RUN, 1, 0, 1, 0);
      for (int i = 0; i < 260; i++) begin
         t = 16 + 15 * i;
         wait_to(t);
         want_loss = (i + 1 > 255) ? 255 : i + 1;
         expect_f(t + 3, "sat_loss", F_LOSS, want_loss);
         expect_f(t + 3, "sat_state", F_ST, S_WAIT);
         pll_lock = 1'b0;
         wait_to(t + 1);
         pll_lock = 1'b1;
      end
      expect_all(16 + 15 * 260, "sat_final_run", S_RUN, 1, 0, 1, 0);
      expect_f(16 + 15 * 260, "sat_final_loss", F_LOSS, 255);
      wait_drain(100);

      // Reset while running behaves like power-up.
      do_reset();
      expect_all(0, "midreset", S_PWRDN, 0, 1, 0, 0);
      expect_f(0, "midreset", F_LOSS, 0);
      expect_f(0, "midreset", F_RET, 0);
      expect_all(16, "midreset_run", S_RUN, 1, 0, 1, 0);
      expect_f(16, "midreset_run", F_LOSS, 0);
      wait_drain(100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
